bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width shared by both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive data grants allowed while fetch waits.
REQ-004 One clock and an asynchronous, active-low reset; ports clk and async_rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 async_rst_n  in  1  asynchronous reset, active low.
REQ-007 f_req  in  1  fetch read request, held until f_ack.
REQ-008 f_addr  in  ADDR_W  fetch word address.
REQ-009 f_rdata  out  DATA_W  fetch read data, valid with f_ack.
REQ-010 f_ack  out  1  one-cycle fetch completion pulse.
REQ-011 d_req  in  1  load/store request, held until d_ack.
REQ-012 d_we, d_lock  in  1 each  write enable (MEMORY_MODE) and bus lock (BUS_LOCK) from the control word.
REQ-013 d_addr, d_wdata, d_be  in  ADDR_W/DATA_W/4  data address, write data, byte enables.
REQ-014 d_rdata  out  DATA_W;  d_ack  out  1  data read data and one-cycle completion pulse.
REQ-015 m_req, m_we  out  1;  m_addr, m_wdata, m_be  out  ADDR_W/DATA_W/4  registered memory request.
REQ-016 m_rdata  in  DATA_W;  m_ack  in  1  memory completion, one cycle.
REQ-017 pipe_stall  out  1  high while any asserted requester has not received its ack.
REQ-018 owner  out  2  current bus owner: 0 none, 1 fetch, 2 data, 3 locked-data.

Function
REQ-019 FSM states IDLE, F_BUSY, D_BUSY, LOCKED; one outstanding memory transaction at a time.
REQ-020 IDLE: d_req wins over f_req unless starve count == STARVE_LIMIT, then fetch wins; grant registers m_* fields and m_req=1 on the next edge (one-cycle grant latency).
REQ-021 F_BUSY/D_BUSY: m_req and all m_* fields held stable until m_ack; m_ack returns to IDLE, or to LOCKED if D_BUSY transaction had d_lock=1.
REQ-022 LOCKED: only d_req is granted (to D_BUSY); f_req waits; LOCKED exits to IDLE when d_req=0 and d_lock=0, or after a granted data transaction with d_lock=0 completes.
REQ-023 f_ack = m_ack in F_BUSY; d_ack = m_ack in D_BUSY; rdata routed combinationally from m_rdata; acks never asserted otherwise.
REQ-024 m_ack in IDLE or LOCKED without a request in flight is ignored.
REQ-025 Back-to-back: a request present in the ack cycle is granted with m_req re-asserted on the following edge; m_req is low for exactly one cycle between transactions.
REQ-026 Starve counter: increments on each data grant while f_req=1, saturates at STARVE_LIMIT, clears on fetch grant or when f_req=0.
REQ-027 Starve override is suppressed in LOCKED; counter still saturates.
REQ-028 A requester dropping its req mid-transaction does not abort it; the transaction completes and the ack pulse is still produced.
REQ-029 pipe_stall = (f_req & ~f_ack) | (d_req & ~d_ack), combinational.
REQ-030 Simultaneous f_req and d_req rising in the same IDLE cycle with counter 0: data granted, fetch granted after d_ack.

Reset
REQ-031 async_rst_n low: state IDLE, m_req=0, m_we=0, m_addr/m_wdata/m_be=0, owner=0, starve counter=0; f_ack/d_ack=0 (derived from state).
REQ-032 Reset mid-transaction abandons it; no ack is produced for it after reset release.

Structure
REQ-033 Package srv1_bus_pkg holds the state enum, owner encoding and default STARVE_LIMIT.
REQ-034 Sub-module arb_starve_counter (saturating counter, inc/clear/sat) is the sole child instance.

Verification
REQ-035 f_req=1, f_addr=0x100, m_ack returned 3 cycles after m_req with m_rdata=0xDEADBEEF -> m_addr=0x100 one cycle after f_req; f_ack pulse with f_rdata=0xDEADBEEF.
REQ-036 f_req and d_req asserted together, d_we=1, d_addr=0x20 -> data transaction first, fetch m_req re-asserted exactly one idle cycle after d_ack.
REQ-037 d_req held continuously with f_req=1, STARVE_LIMIT=4 -> four data grants, then one fetch grant, counter back to 0.
REQ-038 d_lock=1 store completes, f_req=1 pending -> owner=3, fetch not granted; d_lock=0 load completes -> IDLE, fetch granted next.
REQ-039 async_rst_n pulsed low during D_BUSY, m_ack arrives after release -> no d_ack, m_req=0, state IDLE.

Source files
------------

// File: rtl/srv1_bus_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
//   arb_state_e        : arbiter FSM state encoding
//   Owner*             : encoding of the 'owner' status output
//   DefaultStarveLimit : data grants allowed back-to-back while a fetch waits
package srv1_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFBusy  = 2'd1,
    StDBusy  = 2'd2,
    StLocked = 2'd3
  } arb_state_e;

  localparam logic [1:0] OwnerNone   = 2'd0;
  localparam logic [1:0] OwnerFetch  = 2'd1;
  localparam logic [1:0] OwnerData   = 2'd2;
  localparam logic [1:0] OwnerLocked = 2'd3;

  localparam int unsigned DefaultStarveLimit = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter tracking how many data grants have gone by while fetch waits.
//   clk, async_rst_n : clock, asynchronous active-low reset
//   inc              : count one data grant (ignored once saturated)
//   clr              : return to zero; wins over inc
//   sat              : count has reached LIMIT
module arb_starve_counter
  import srv1_bus_pkg::*;
#(
  parameter int unsigned LIMIT = DefaultStarveLimit
) (
  input  logic clk,
  input  logic async_rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CntW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CntW-1:0] LimitVal = CntW'(LIMIT);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LimitVal)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sat = (count_q == LimitVal);

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port, with one
// outstanding transaction, data priority, fetch anti-starvation and bus lock.
//   clk, async_rst_n          : clock, asynchronous active-low reset
//   f_req/f_addr              : fetch read request (held until f_ack)
//   f_rdata/f_ack             : fetch read data and one-cycle completion
//   d_req/d_we/d_lock         : data request, write enable, bus lock
//   d_addr/d_wdata/d_be       : data address, write data, byte enables
//   d_rdata/d_ack             : data read data and one-cycle completion
//   m_req/m_we/m_addr/...     : registered memory request, stable until m_ack
//   m_rdata/m_ack             : memory read data and one-cycle completion
//   pipe_stall                : some requester is still waiting for its ack
//   owner                     : 0 none, 1 fetch, 2 data, 3 locked-data
module bus_arbiter
  import srv1_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              pipe_stall,
  output logic [1:0]        owner
);

  arb_state_e state_q, state_d;
  logic       grant_f, grant_d;
  logic       lock_q;       // lock bit of the data transaction in flight
  logic       starve_sat;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .inc        (grant_d & f_req),
    .clr        (grant_f | ~f_req),
    .sat        (starve_sat)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Data normally wins; a saturated starve count hands the slot to fetch.
        if (d_req && !(f_req && starve_sat)) begin
          grant_d = 1'b1;
          state_d = StDBusy;
        end else if (f_req) begin
          grant_f = 1'b1;
          state_d = StFBusy;
        end
      end
      StFBusy: begin
        if (m_ack) state_d = StIdle;
      end
      StDBusy: begin
        if (m_ack) state_d = lock_q ? StLocked : StIdle;
      end
      StLocked: begin
        // Fetch is never served while the bus is locked.
        if (d_req) begin
          grant_d = 1'b1;
          state_d = StDBusy;
        end else if (!d_lock) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    m_req = (state_q == StFBusy) || (state_q == StDBusy);
    f_ack = (state_q == StFBusy) && m_ack;
    d_ack = (state_q == StDBusy) && m_ack;
    unique case (state_q)
      StIdle:   owner = OwnerNone;
      StFBusy:  owner = OwnerFetch;
      StDBusy:  owner = OwnerData;
      StLocked: owner = OwnerLocked;
    endcase
  end

  // Request fields are only loaded on a grant, so they stay put until m_ack.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      lock_q  <= 1'b0;
    end else if (grant_d) begin
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_be;
      lock_q  <= d_lock;
    end else if (grant_f) begin
      m_we    <= 1'b0;
      m_addr  <= f_addr;
      m_wdata <= '0;
      m_be    <= 4'hF;
      lock_q  <= 1'b0;
    end
  end

  assign f_rdata    = m_rdata;
  assign d_rdata    = m_rdata;
  assign pipe_stall = (f_req & ~f_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a memory responder checks each issued request
// against a queue of expected transactions, and an ack monitor checks every
// f_ack/d_ack pulse against a queue of expected completions.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        f_req, f_ack, d_req, d_we, d_lock, d_ack;
  logic [29:0] f_addr, d_addr, m_addr;
  logic [31:0] f_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
  logic [3:0]  d_be, m_be;
  logic        m_req, m_we, m_ack, pipe_stall;
  logic [1:0]  owner;

  typedef struct {
    bit          is_fetch;
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  typedef struct {
    bit          is_fetch;
    logic [31:0] rdata;
  } ack_t;

  txn_t txn_q[$];
  ack_t ack_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat   = 3;

  bus_arbiter dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_rdata    (f_rdata),
    .f_ack      (f_ack),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_lock     (d_lock),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_be       (m_be),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack),
    .pipe_stall (pipe_stall),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input bit is_fetch, input logic [29:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] rdata, input bit expect_ack);
    txn_t t;
    ack_t a;
    t.is_fetch = is_fetch; t.addr = addr; t.we = we; t.be = be; t.wdata = wdata;
    t.rdata = rdata;
    txn_q.push_back(t);
    if (expect_ack) begin
      a.is_fetch = is_fetch; a.rdata = rdata;
      ack_q.push_back(a);
    end
  endtask

  task automatic wait_ack(input bit fetch, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(fetch ? f_ack : d_ack) && cycles < 40);
    if (!(fetch ? f_ack : d_ack)) check(fetch ? "f_ack_timeout" : "d_ack_timeout", 0, 1);
  endtask

  // Memory responder: acks 'lat' cycles after m_req, checks request fields.
  // Deliberately ignores reset so a stale ack can arrive after reset release.
  initial begin : responder
    bit          active = 0;
    int          cnt = 0;
    logic [31:0] cur_rdata = '0;
    txn_t        e;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_ack) begin
        m_ack = 1'b0;
        active = 0;
      end else if (active) begin
        cnt++;
        if (cnt >= lat) begin
          m_ack = 1'b1;
          m_rdata = cur_rdata;
        end
      end else if (m_req) begin
        active = 1;
        cnt = 0;
        if (txn_q.size() == 0) begin
          check("unexpected_m_req", 1, 0);
          cur_rdata = '0;
        end else begin
          e = txn_q.pop_front();
          cur_rdata = e.rdata;
          check("m_fields", {m_addr, m_we, e.is_fetch ? 4'h0 : m_be, m_we ? m_wdata : 32'h0},
                {e.addr, e.we, e.is_fetch ? 4'h0 : e.be, e.we ? e.wdata : 32'h0});
        end
      end
    end
  end

  always @(negedge clk) begin : ack_monitor
    ack_t e;
    if (async_rst_n && (f_ack || d_ack)) begin
      check("ack_exclusive", f_ack & d_ack, 0);
      if (ack_q.size() == 0) begin
        check("unexpected_ack", {f_ack, d_ack}, 0);
      end else begin
        e = ack_q.pop_front();
        check("ack_kind", f_ack, e.is_fetch);
        check("ack_rdata", f_ack ? f_rdata : d_rdata, e.rdata);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c;
    int acks;
    async_rst_n = 1'b0;
    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_lock = 0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_m_fields", {m_we, m_addr, m_wdata, m_be}, 0);
    check("rst_owner", owner, 0);
    check("rst_acks", {f_ack, d_ack}, 0);
    check("rst_stall", pipe_stall, 0);
    async_rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, memory latency 3.
    f_req = 1; f_addr = 30'h100;
    push_txn(1, 30'h100, 0, 4'hF, 0, 32'hDEADBEEF, 1);
    #1 check("f_stall", pipe_stall, 1);
    @(negedge clk);
    check("f_grant", {m_req, m_addr, owner}, {1'b1, 30'h100, 2'd1});
    wait_ack(1, c);
    f_req = 0;
    check("f_ack_latency", c, 3);
    @(negedge clk);
    check("f_done", {m_req, owner, pipe_stall}, {1'b0, 2'd0, 1'b0});

    // Simultaneous requests: data first, fetch after one idle cycle.
    f_req = 1; f_addr = 30'h200;
    d_req = 1; d_we = 1; d_addr = 30'h20; d_wdata = 32'h12345678; d_be = 4'hF;
    push_txn(0, 30'h20, 1, 4'hF, 32'h12345678, 32'hA5A5A5A5, 1);
    push_txn(1, 30'h200, 0, 4'hF, 0, 32'hCAFEF00D, 1);
    @(negedge clk);
    check("both_grant_data", {m_req, owner, m_we}, {1'b1, 2'd2, 1'b1});
    wait_ack(0, c);
    d_req = 0; d_we = 0;
    @(negedge clk);
    check("b2b_gap", m_req, 0);
    @(negedge clk);
    check("b2b_fetch", {m_req, owner}, {1'b1, 2'd1});
    wait_ack(1, c);
    f_req = 0;
    @(negedge clk);

    // Starvation: four data grants, then fetch, then data wins again.
    f_req = 1; f_addr = 30'h300;
    d_req = 1; d_we = 0; d_be = 4'hF;
    for (int i = 0; i < 4; i++) push_txn(0, 30'h40 + 30'(i), 0, 4'hF, 0, 32'h4000 + i, 1);
    push_txn(1, 30'h300, 0, 4'hF, 0, 32'h3333, 1);
    push_txn(0, 30'h44, 0, 4'hF, 0, 32'h4444, 1);
    for (int i = 0; i < 4; i++) begin
      d_addr = 30'h40 + 30'(i);
      wait_ack(0, c);
    end
    d_addr = 30'h44;
    wait_ack(1, c);
    f_req = 0;
    check("starve_fetch_latency", c, 5);
    wait_ack(0, c);
    d_req = 0;
    check("post_starve_data_latency", c, 5);
    @(negedge clk);

    // Bus lock: fetch held off until an unlocked data transfer completes.
    f_req = 1; f_addr = 30'h400;
    d_req = 1; d_lock = 1; d_we = 1; d_addr = 30'h50; d_wdata = 32'h11; d_be = 4'h3;
    push_txn(0, 30'h50, 1, 4'h3, 32'h11, 32'h0, 1);
    wait_ack(0, c);
    d_req = 0; d_we = 0;
    @(negedge clk);
    check("locked_owner", {owner, m_req}, {2'd3, 1'b0});
    repeat (3) @(negedge clk);
    check("locked_hold", {owner, m_req}, {2'd3, 1'b0});
    d_req = 1; d_lock = 0; d_addr = 30'h51; d_be = 4'hF;
    push_txn(0, 30'h51, 0, 4'hF, 0, 32'h5151, 1);
    push_txn(1, 30'h400, 0, 4'hF, 0, 32'h0F0F, 1);
    wait_ack(0, c);
    d_req = 0;
    @(negedge clk);
    check("unlock_idle", {owner, m_req}, {2'd0, 1'b0});
    @(negedge clk);
    check("unlock_fetch", {owner, m_req, m_addr}, {2'd1, 1'b1, 30'h400});
    wait_ack(1, c);
    f_req = 0;
    @(negedge clk);

    // Reset during a data transaction; memory ack lands after release.
    lat = 6;
    d_req = 1; d_we = 0; d_addr = 30'h60;
    push_txn(0, 30'h60, 0, 4'hF, 0, 32'h6060, 0);
    @(negedge clk);
    check("rst_mid_grant", {m_req, owner}, {1'b1, 2'd2});
    async_rst_n = 0; d_req = 0;
    #1 check("rst_mid_state", {m_req, owner, m_addr}, {1'b0, 2'd0, 30'h0});
    @(negedge clk);
    async_rst_n = 1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_ack || f_ack) acks++;
    end
    check("rst_no_ack", acks, 0);
    check("rst_after", {m_req, owner}, {1'b0, 2'd0});
    lat = 3;

    repeat (3) @(negedge clk);
    check("txn_q_empty", txn_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
